// File: rtl/fa_mux4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fa_mux4_pkg : tie-off constants for the mux-based full adder      |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package fa_mux4_pkg;

    localparam logic c_TIE_LO = 1'b0;
    localparam logic c_TIE_HI = 1'b1;

endpackage : fa_mux4_pkg
`default_nettype wire

// File: rtl/fa_mux4_mux4_1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux4_1 : combinational 4:1 one-bit multiplexer, i_sel[1] is MSB   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module mux4_1 (
    input  logic [1:0] i_sel,
    input  logic       i_d0,
    input  logic       i_d1,
    input  logic       i_d2,
    input  logic       i_d3,
    output logic       o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'b00:   o_y = i_d0;
            2'b01:   o_y = i_d1;
            2'b10:   o_y = i_d2;
            2'b11:   o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end

endmodule : mux4_1
`default_nettype wire

// File: rtl/fa_mux4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fa_mux4 : registered 1-bit full adder, sum/carry built from muxes |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module fa_mux4
    import fa_mux4_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic X,
    input  logic Y,
    input  logic Z,
    output logic C,
    output logic S
);

    logic [1:0] w_sel;
    logic       w_z_n;
    logic       w_sum;
    logic       w_carry;
    logic       r_c;
    logic       r_s;

    assign w_sel = {X, Y};
    assign w_z_n = ~Z;

    // Sum is Z when X==Y, its complement otherwise: X^Y^Z.
    mux4_1 u_sum_mux (
        .i_sel (w_sel),
        .i_d0  (Z),
        .i_d1  (w_z_n),
        .i_d2  (w_z_n),
        .i_d3  (Z),
        .o_y   (w_sum)
    );

    // Carry is decided by X,Y when they agree, by Z when they differ.
    mux4_1 u_carry_mux (
        .i_sel (w_sel),
        .i_d0  (c_TIE_LO),
        .i_d1  (Z),
        .i_d2  (Z),
        .i_d3  (c_TIE_HI),
        .o_y   (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c <= 1'b0;
            r_s <= 1'b0;
        end else begin
            r_c <= w_carry;
            r_s <= w_sum;
        end
    end

    assign C = r_c;
    assign S = r_s;

endmodule : fa_mux4
`default_nettype wire

// File: tb/tb_fa_mux4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fa_mux4 : directed self-checking bench for fa_mux4             |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_fa_mux4;

    logic clk;
    logic rst_n;
    logic X;
    logic Y;
    logic Z;
    logic C;
    logic S;

    int n_tests;
    int n_fail;

    fa_mux4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .C     (C),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed CS=%b expected CS=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic [2:0] xyz);
        {X, Y, Z} = xyz;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_exp [8];
    logic [2:0] xyz_v;
    logic [1:0] model;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tt_exp  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset held with all inputs high
        rst_n = 1'b0;
        {X, Y, Z} = 3'b111;
        @(negedge clk);
        step(3'b111); check("reset_edge1", {C, S}, 2'b00);
        step(3'b111); check("reset_edge2", {C, S}, 2'b00);

        // Exhaustive truth table, plus arithmetic identity on captured inputs
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xyz_v = i[2:0];
            model = 2'(xyz_v[2]) + 2'(xyz_v[1]) + 2'(xyz_v[0]);
            step(xyz_v);
            check($sformatf("truth_%0d", i), {C, S}, tt_exp[i]);
            check($sformatf("sum_id_%0d", i), {C, S}, model);
        end

        // Latency: change inputs midway between edges
        step(3'b000); check("lat_base", {C, S}, 2'b00);
        @(negedge clk);
        {X, Y, Z} = 3'b111;
        #1; check("lat_mid1", {C, S}, 2'b00);
        #3; check("lat_mid2", {C, S}, 2'b00);
        @(posedge clk); #1;
        check("lat_after", {C, S}, 2'b11);

        // Reset in the middle of the stream
        rst_n = 1'b0;
        step(3'b111); check("mid_reset", {C, S}, 2'b00);
        rst_n = 1'b1;
        step(3'b011); check("reset_release", {C, S}, 2'b10);

        // Back-to-back input changes
        step(3'b001); check("b2b_001", {C, S}, 2'b01);
        step(3'b110); check("b2b_110", {C, S}, 2'b10);
        step(3'b100); check("b2b_100", {C, S}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fa_mux4
`default_nettype wire
